// File: rtl/n_bit_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
// Trial subtraction reuses the ripple-carry adder in subtract mode.

module n_bit_ripple_carry_adder #(
    parameter int BIT_NUM = 4
) (
    input  logic [BIT_NUM-1:0] op1_i,
    input  logic [BIT_NUM-1:0] op2_i,
    input  logic               sgn_op2,
    output logic [BIT_NUM-1:0] sum_o,
    output logic               carry_o
);

    logic [BIT_NUM:0]   carry;
    logic [BIT_NUM-1:0] op2_eff;

    // Subtraction is op1 + ~op2 + 1, so carry_o = 1 means no borrow.
    assign carry[0] = sgn_op2;
    assign op2_eff  = op2_i ^ {BIT_NUM{sgn_op2}};

    for (genvar i = 0; i < BIT_NUM; i++) begin : g_fa
        assign sum_o[i]     = op1_i[i] ^ op2_eff[i] ^ carry[i];
        assign carry[i + 1] = (op1_i[i] & op2_eff[i]) | (carry[i] & (op1_i[i] ^ op2_eff[i]));
    end

    assign carry_o = carry[BIT_NUM];

endmodule

module n_bit_restoring_divider #(
    parameter int BIT_NUM = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [BIT_NUM-1:0] dividend_i,
    input  logic [BIT_NUM-1:0] divisor_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [BIT_NUM-1:0] quotient_o,
    output logic [BIT_NUM-1:0] remainder_o,
    output logic               div_by_zero_o,
    output logic               valid_o,
    input  logic               ready_i
);

    localparam int CNT_W = $clog2(BIT_NUM + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [BIT_NUM-1:0] q_q, q_d;
    logic [BIT_NUM-1:0] r_q, r_d;
    logic [BIT_NUM-1:0] d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

    logic [BIT_NUM:0]   trial_src;
    logic [BIT_NUM:0]   trial_diff;
    logic               no_borrow;
    logic               unused_diff_msb;

    assign trial_src = {r_q, q_q[BIT_NUM-1]};

    n_bit_ripple_carry_adder #(
        .BIT_NUM (BIT_NUM + 1)
    ) u_sub (
        .op1_i   (trial_src),
        .op2_i   ({1'b0, d_q}),
        .sgn_op2 (1'b1),
        .sum_o   (trial_diff),
        .carry_o (no_borrow)
    );

    // R < D always holds, so the MSB of a non-borrowing difference is zero.
    assign unused_diff_msb = trial_diff[BIT_NUM];

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    d_d   = divisor_i;
                    cnt_d = CNT_W'(BIT_NUM);
                    if (divisor_i == '0) begin
                        q_d     = '1;
                        r_d     = dividend_i;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = dividend_i;
                        r_d     = '0;
                        dbz_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (no_borrow) begin
                    r_d = trial_diff[BIT_NUM-1:0];
                    q_d = {q_q[BIT_NUM-2:0], 1'b1};
                end else begin
                    r_d = trial_src[BIT_NUM-1:0];
                    q_d = {q_q[BIT_NUM-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state.
    assign ready_d = (state_d == IDLE);
    assign valid_d = (state_d == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o       = ready_q;
    assign valid_o       = valid_q;
    assign quotient_o    = q_q;
    assign remainder_o   = r_q;
    assign div_by_zero_o = dbz_q;

endmodule
